// File: rtl/ps2_keyboard_if.sv
// Host-side read bus of the PS/2 keyboard receiver: pop request, FIFO head and status.
interface ps2_keyboard_if;
  logic       rd;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       parity_err;

  modport master (output rd, input data, input ready, input overflow, input parity_err);
  modport slave  (input rd, output data, output ready, output overflow, output parity_err);
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: conditions the raw pins, deserialises 11-bit frames
// and buffers scan codes in a first-word-fall-through FIFO.
//
// state  | meaning
// IDLE   | waiting for a start bit (dat=0 on a clk fall)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit, then pushing or flagging the frame
module ps2_keyboard #(
  parameter int FILTER         = 4,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           ps2_clk,
  input  logic           ps2_dat,
  ps2_keyboard_if.slave  bus
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt, clk_filt_q;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state, state_d;
  logic [2:0]    bitcnt, bitcnt_d;
  logic [7:0]    shreg, shreg_d;
  logic          par_ok, par_ok_d;
  logic          push_d, push_q;
  logic          perr_d, perr_q;
  logic [TW-1:0] to_cnt;
  logic          timeout;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow_q;
  logic          full, pop, wr_ok;

  // clk level is accepted only after FILTER consecutive samples disagree with it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      dat_s1     <= ps2_dat;
      dat_s2     <= dat_s1;
      clk_filt_q <= clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall    = clk_filt_q & ~clk_filt;
  assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state;
    bitcnt_d = bitcnt;
    shreg_d  = shreg;
    par_ok_d = par_ok;
    push_d   = 1'b0;
    perr_d   = 1'b0;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end
        end
        DATA: begin
          shreg_d  = {dat_s2, shreg[7:1]};
          bitcnt_d = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_ok_d = ^{shreg, dat_s2};
          state_d  = STOP;
        end
        STOP: begin
          if (par_ok && dat_s2) push_d = 1'b1;
          else                  perr_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      par_ok <= 1'b0;
      push_q <= 1'b0;
      perr_q <= 1'b0;
      to_cnt <= '0;
    end else begin
      state  <= state_d;
      bitcnt <= bitcnt_d;
      shreg  <= shreg_d;
      par_ok <= par_ok_d;
      push_q <= push_d;
      perr_q <= perr_d;
      if (timeout || fall || state == IDLE) to_cnt <= '0;
      else                                  to_cnt <= to_cnt + TW'(1);
    end
  end

  // shreg is stable until the next start bit, so push_q can write it directly
  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = bus.rd && (count != '0);
  assign wr_ok = push_q && (!full || pop);

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      if (wr_ok && !pop)      count <= count + CW'(1);
      else if (!wr_ok && pop) count <= count - CW'(1);
      if (push_q && full && !pop)                   overflow_q <= 1'b1;
      else if (pop && !push_q && count == CW'(1))   overflow_q <= 1'b0;
    end
  end

  assign bus.ready      = (count != '0);
  assign bus.data       = (count != '0) ? mem[rd_ptr] : 8'h00;
  assign bus.overflow   = overflow_q;
  assign bus.parity_err = perr_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: frames are bit-banged on the PS/2 pins with a
// shortened bit period and timeout so every scenario fits in a short run.
module tb_ps2_keyboard;

  localparam int HALF    = 20;
  localparam int TIMEOUT = 200;

  logic clock = 1'b0;
  logic reset_n, ps2_clk, ps2_dat;
  int   n_cmp = 0, n_bad = 0;
  int   perr_cycles = 0;
  int   p0;

  ps2_keyboard_if kb_if ();

  ps2_keyboard #(.FILTER(4), .TIMEOUT_CYCLES(TIMEOUT), .FIFO_DEPTH(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .bus     (kb_if)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (kb_if.parity_err) perr_cycles++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic opar(input logic [7:0] b);
    return ~^b;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic put_bit(input logic v, input int glitch);
    @(negedge clock);
    ps2_dat = v;
    if (glitch > 0) begin
      wait_cyc(8);
      ps2_clk = 1'b0;
      wait_cyc(glitch);
      ps2_clk = 1'b1;
      wait_cyc(HALF - 8 - glitch);
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int glitch);
    logic [10:0] bits;
    bits = {stp, par, b, 1'b0};
    for (int i = 0; i < 11; i++) put_bit(bits[i], glitch);
    ps2_dat = 1'b1;
    wait_cyc(30);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, opar(b), 1'b1, 0);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    put_bit(1'b0, 0);
    for (int i = 0; i < nbits; i++) put_bit(b[i], 0);
    ps2_dat = 1'b1;
  endtask

  task automatic pop_one;
    @(negedge clock);
    kb_if.rd = 1'b1;
    @(negedge clock);
    kb_if.rd = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_dat  = 1'b1;
    kb_if.rd = 1'b0;
    wait_cyc(5);
    check("rst_ready", 32'(kb_if.ready), 32'h0);
    check("rst_data", 32'(kb_if.data), 32'h00);
    check("rst_ovf", 32'(kb_if.overflow), 32'h0);
    check("rst_perr", 32'(kb_if.parity_err), 32'h0);
    reset_n = 1'b1;
    wait_cyc(10);

    // 1: clean 0x1C
    p0 = perr_cycles;
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    check("t1_ready", 32'(kb_if.ready), 32'h1);
    check("t1_data", 32'(kb_if.data), 32'h1C);
    check("t1_perr", 32'(perr_cycles - p0), 32'd0);
    pop_one();
    check("t1_empty", 32'(kb_if.ready), 32'h0);

    // 2: bad parity, then bad stop bit
    p0 = perr_cycles;
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    check("t2_par_pulse", 32'(perr_cycles - p0), 32'd1);
    check("t2_par_ready", 32'(kb_if.ready), 32'h0);
    p0 = perr_cycles;
    send_frame(8'h1C, 1'b0, 1'b0, 0);
    check("t2_stop_pulse", 32'(perr_cycles - p0), 32'd1);
    check("t2_stop_ready", 32'(kb_if.ready), 32'h0);

    // 3: overflow with 9 bytes into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    check("t3_ready", 32'(kb_if.ready), 32'h1);
    check("t3_ovf", 32'(kb_if.overflow), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("t3_pop%0d", i), 32'(kb_if.data), 32'(i));
      if (i == 8) check("t3_ovf_before_last", 32'(kb_if.overflow), 32'h1);
      pop_one();
    end
    check("t3_ovf_clr", 32'(kb_if.overflow), 32'h0);
    check("t3_empty", 32'(kb_if.ready), 32'h0);
    check("t3_data0", 32'(kb_if.data), 32'h00);

    // 4: FWFT order and rd while empty
    send_byte(8'h2A);
    send_byte(8'hF0);
    check("t4_head", 32'(kb_if.data), 32'h2A);
    pop_one();
    check("t4_next", 32'(kb_if.data), 32'hF0);
    check("t4_ready", 32'(kb_if.ready), 32'h1);
    pop_one();
    pop_one();
    check("t4_empty_rd_data", 32'(kb_if.data), 32'h00);
    check("t4_empty_rd_ready", 32'(kb_if.ready), 32'h0);
    send_byte(8'h33);
    check("t4_after_empty_rd", 32'(kb_if.data), 32'h33);
    pop_one();

    // 5: partial frame discarded by timeout
    p0 = perr_cycles;
    send_partial(8'h0F, 4);
    wait_cyc(TIMEOUT * 2 + 100);
    check("t5_partial_ready", 32'(kb_if.ready), 32'h0);
    send_byte(8'h5A);
    check("t5_data", 32'(kb_if.data), 32'h5A);
    check("t5_perr", 32'(perr_cycles - p0), 32'd0);
    pop_one();
    check("t5_single", 32'(kb_if.ready), 32'h0);

    // 6: glitches on ps2_clk, then reset mid-frame
    p0 = perr_cycles;
    send_frame(8'h77, opar(8'h77), 1'b1, 1);
    send_frame(8'h3C, opar(8'h3C), 1'b1, 3);
    check("t6_g1", 32'(kb_if.data), 32'h77);
    pop_one();
    check("t6_g3", 32'(kb_if.data), 32'h3C);
    check("t6_perr", 32'(perr_cycles - p0), 32'd0);
    send_partial(8'h55, 3);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("t6_rst_ready", 32'(kb_if.ready), 32'h0);
    check("t6_rst_data", 32'(kb_if.data), 32'h00);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(10);
    send_byte(8'hA5);
    check("t6_after_rst", 32'(kb_if.data), 32'hA5);
    check("t6_after_rst_ready", 32'(kb_if.ready), 32'h1);
    pop_one();
    check("t6_after_rst_empty", 32'(kb_if.ready), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
